fetch_sequencer: RTL
====================

// Module: fetch_sequencer
// PURPOSE
//  Upstream of the instruction decoder: 8-state machine cycle timing A1..X3 (cycle 0..7).
//  Drives the 12-bit PC out as nibbles during A1-A3 and latches OPR/OPA from the 4-bit ROM bus in M1/M2.
//  Tracks two-word instructions and captures the second byte into imm8.
//  Applies PC load (jump) or increment at X3.
//  Supplies cycle/opr/opa to the decoder and imm8 to FIM/JUN/JMS/JCN/ISZ datapaths.
// PARAMETERS
//  PC_WIDTH  12      program counter width (ROM address space 4096 bytes)
//  RESET_PC  12'h000 PC value after reset
// PORTS
//  clk         in   1   system clock, all state on rising edge
//  rstN        in   1   async active-low reset
//  runEn       in   1   1 = advance one machine-cycle state per clk; 0 = freeze all state
//  romData     in   4   ROM data nibble, valid during M1 (cycle 3) and M2 (cycle 4)
//  jumpEn      in   1   PC load request, sampled only when cycle==7 and runEn==1
//  jumpAddr    in   12  PC load value
//  cycle       out  3   machine state: 0-2 A1-A3, 3-4 M1-M2, 5-7 X1-X3
//  sync        out  1   high while cycle==7; marks the next clk as the start of A1
//  addrNibble  out  4   PC nibble for the ROM: A1=pc[3:0], A2=pc[7:4], A3=pc[11:8], else 0
//  pc          out  12  current program counter
//  opr         out  4   opcode of the current instruction
//  opa         out  4   operand of the current instruction
//  imm8        out  8   second instruction byte {M1 nibble, M2 nibble}
//  secondWord  out  1   1 while the second word of a two-word instruction is being fetched
//  instrDone   out  1   high during cycle 7 of the final word of each instruction
// BEHAVIOUR
//  Reset (async, rstN=0)
//   - cycle=0, pc=RESET_PC, opr=opa=0 (NOP), imm8=0, secondWord=0.
//   - sync=0, instrDone=0, addrNibble=RESET_PC[3:0].
//   - Reset mid-instruction discards any partial fetch; the first instruction after reset starts at A1.
//  Counter and outputs
//   - When runEn=1, cycle increments 0->7 and wraps 7->0. When runEn=0, cycle, pc, opr, opa, imm8 and secondWord hold.
//   - sync, instrDone and addrNibble are decoded from the registered state (no comb path from inputs).
//  M1/M2 capture
//   - Word 1 (secondWord=0): at the M1 edge (cycle 3->4) opr<=romData; at the M2 edge (4->5) opa<=romData.
//     opr/opa are valid from cycle 5 (X1) on, and stay stable until the next word-1 M1.
//   - Word 2 (secondWord=1): the M1 edge loads imm8[7:4]; the M2 edge loads imm8[3:0]; opr/opa hold.
//     imm8 is valid from X1 of word 2. imm8 is held otherwise and is never cleared except by reset.
//  Two-word detection (on the registered opr/opa at X3 of word 1)
//   - Two-word when opr==1 (JCN), opr==2 with opa[0]==0 (FIM), opr==4 (JUN), opr==5 (JMS) or opr==7 (ISZ).
//   - When two-word: secondWord<=1 at the 7->0 edge, and instrDone=0 during that X3.
//   - At X3 of word 2, secondWord<=0 and instrDone=1.
//   - One-word instructions: instrDone=1 at X3, secondWord stays 0.
//  PC update (only at the 7->0 edge with runEn=1)
//   - jumpEn=1: pc<=jumpAddr. Jump has priority over increment. jumpEn in cycles 0-6 is ignored.
//   - Otherwise pc<=pc+1, modulo 2^PC_WIDTH (12'hFFF -> 12'h000, no flag).
//   - A jump during X3 of word 1 of a two-word instruction still sets secondWord.
//     The second word is then fetched from jumpAddr; the owner of jumpEn must not do this.
//  Timing with the decoder
//   - The decoder registers its controls on the cycle value, so the enables it asserts for cycle 7 take effect at the 7->0 edge.
//   - jumpEn must be presented combinationally during cycle 7.
// TESTING
//  1 Reset: hold rstN=0, then release; run 8 clks with romData=0 -> cycle 0..7, sync only at 7, pc 000->001, instrDone=1 at cycle 7.
//  2 JUN: ROM nibbles 4,1 then 2,3 -> opr=4, opa=1 from X1; secondWord=1 in the 2nd pass; imm8=8'h23 at X1 of word 2;
//    instrDone only at the 2nd X3; jumpEn=1, jumpAddr=12'h123 at that X3 -> pc=123 and addrNibble sequence 3,2,1.
//  3 FIM vs SRC: opr=2, opa=4 -> two-word; opr=2, opa=5 -> one-word, instrDone at the first X3.
//  4 Wrap: preset pc=FFF via jump, run a NOP -> pc=000 with no other state disturbed.
//  5 runEn=0 for 5 clks at cycle 3 -> all outputs frozen; resume -> M1 capture happens exactly once.
//  6 Assert rstN=0 at cycle 4 of word 2 -> immediate reset values, secondWord=0, then a normal fetch from RESET_PC.

Source files
------------

// File: rtl/fetch_sequencer.sv
// fetch_sequencer: eight-state machine-cycle sequencer for instruction fetch.
// Drives PC nibbles, captures OPR/OPA or the immediate byte, and steps the PC.
module fetch_sequencer #(
    parameter int                    PC_WIDTH = 12,
    parameter logic [PC_WIDTH-1:0]   RESET_PC = '0
) (
    input  logic                clk,
    input  logic                rstN,
    input  logic                runEn,
    input  logic [3:0]          romData,
    input  logic                jumpEn,
    input  logic [PC_WIDTH-1:0] jumpAddr,
    output logic [2:0]          cycle,
    output logic                sync,
    output logic [3:0]          addrNibble,
    output logic [PC_WIDTH-1:0] pc,
    output logic [3:0]          opr,
    output logic [3:0]          opa,
    output logic [7:0]          imm8,
    output logic                secondWord,
    output logic                instrDone
);

    typedef enum logic [2:0] {
        A1 = 3'd0,
        A2 = 3'd1,
        A3 = 3'd2,
        M1 = 3'd3,
        M2 = 3'd4,
        X1 = 3'd5,
        X2 = 3'd6,
        X3 = 3'd7
    } cycle_e;

    cycle_e      state;
    cycle_e      stateNext;
    logic        isTwoWord;
    logic [11:0] pcExt;

    // Word-1 opcodes whose operand byte follows in a second word
    assign isTwoWord = (opr == 4'd1)
                    || (opr == 4'd2 && !opa[0])
                    || (opr == 4'd4)
                    || (opr == 4'd5)
                    || (opr == 4'd7);

    assign pcExt = 12'(pc);
    assign cycle = state;

    // State register; every register freezes while runEn is low
    always_ff @(posedge clk or negedge rstN) begin
        if (!rstN) begin
            state <= A1;
        end else begin
            state <= stateNext;
        end
    end

    // Next state and registered-state output decode
    always_comb begin
        stateNext  = state;
        sync       = 1'b0;
        instrDone  = 1'b0;
        addrNibble = 4'h0;
        if (runEn) begin
            stateNext = cycle_e'(state + 3'd1);
        end
        case (state)
            A1: addrNibble = pcExt[3:0];
            A2: addrNibble = pcExt[7:4];
            A3: addrNibble = pcExt[11:8];
            X3: begin
                sync      = 1'b1;
                instrDone = secondWord || !isTwoWord;
            end
            default: ;
        endcase
    end

    // Nibble capture, two-word tracking and PC step at the X3 edge
    always_ff @(posedge clk or negedge rstN) begin
        if (!rstN) begin
            pc         <= RESET_PC;
            opr        <= 4'h0;
            opa        <= 4'h0;
            imm8       <= 8'h00;
            secondWord <= 1'b0;
        end else if (runEn) begin
            case (state)
                M1: begin
                    if (secondWord) imm8[7:4] <= romData;
                    else            opr       <= romData;
                end
                M2: begin
                    if (secondWord) imm8[3:0] <= romData;
                    else            opa       <= romData;
                end
                X3: begin
                    secondWord <= !secondWord && isTwoWord;
                    if (jumpEn) pc <= jumpAddr;
                    else        pc <= pc + PC_WIDTH'(1);
                end
                default: ;
            endcase
        end
    end

endmodule
